// File: rtl/avl_pkg.sv
// Shared types for the Avalon-MM DDR stand-in responder: FSM encodings and
// the packed read-command width.
package avl_pkg;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_BURST = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_BEAT = 2'd2
  } rd_state_t;

  // A queued read command is {addr, size}.
  function automatic int rq_cmd_width(input int addr_w, input int size_w);
    return addr_w + size_w;
  endfunction

endpackage

// File: rtl/avl_rq_fifo.sv
// Read-command FIFO: synchronous push/pop, head word visible combinationally,
// pointer-based full/empty with one wrap bit.
module avl_rq_fifo #(
  parameter int WIDTH     = 33,
  parameter int DEPTH_LOG = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG;

  logic [WIDTH-1:0]   store [DEPTH];
  logic [DEPTH_LOG:0] wr_ptr;
  logic [DEPTH_LOG:0] rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[DEPTH_LOG] != rd_ptr[DEPTH_LOG]) &&
                    (wr_ptr[DEPTH_LOG-1:0] == rd_ptr[DEPTH_LOG-1:0]);
  assign pop_data = store[rd_ptr[DEPTH_LOG-1:0]];

  // Pointer update; reset flushes the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Command storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push && !full) store[wr_ptr[DEPTH_LOG-1:0]] <= push_data;
  end

endmodule

// File: rtl/avl_ddr_responder.sv
// Avalon-MM responder standing in for the DDR2 local port: on-chip beat
// memory, burst writes with byte enables, fixed-latency read bursts and
// programmable avl_ready back-pressure.
module avl_ddr_responder
  import avl_pkg::*;
#(
  parameter int AVL_ADDR       = 30,
  parameter int AVL_SIZE       = 3,
  parameter int AVL_BE         = 32,
  parameter int AVL_DATA_WIDTH = 256,
  parameter int MEM_DEPTH_LOG  = 10,
  parameter int RD_LATENCY     = 8,
  parameter int RQ_DEPTH_LOG   = 2,
  parameter int STALL_EVERY    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      avl_ready,
  input  logic [AVL_ADDR-1:0]       avl_addr,
  input  logic [AVL_SIZE-1:0]       avl_size,
  input  logic [AVL_DATA_WIDTH-1:0] avl_wdata,
  output logic [AVL_DATA_WIDTH-1:0] avl_rdata,
  input  logic                      avl_write_req,
  input  logic                      avl_read_req,
  output logic                      avl_rdata_valid,
  input  logic [AVL_BE-1:0]         avl_be,
  input  logic                      avl_burstbegin,
  output logic                      prot_err
);

  localparam int MEM_DEPTH = 2 ** MEM_DEPTH_LOG;
  localparam int RQ_W      = rq_cmd_width(AVL_ADDR, AVL_SIZE);
  localparam int CNT_W     = $clog2(RD_LATENCY);
  localparam int ST_W      = (STALL_EVERY > 2) ? $clog2(STALL_EVERY) : 1;

  function automatic logic [AVL_DATA_WIDTH-1:0] be_merge(
    input logic [AVL_DATA_WIDTH-1:0] old_word,
    input logic [AVL_DATA_WIDTH-1:0] new_word,
    input logic [AVL_BE-1:0]         be
  );
    logic [AVL_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < AVL_BE; b++)
      if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    return merged;
  endfunction

  logic [AVL_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                      run;
  logic [ST_W-1:0]           stall_cnt;
  logic                      stall_tick;
  logic                      rq_full, rq_empty, rq_push, rq_pop;
  logic [RQ_W-1:0]           rq_head;
  logic                      wr_acc, rd_acc;

  wr_state_t                 wr_state, wr_state_nx;
  logic [AVL_ADDR-1:0]       wr_addr;
  logic [AVL_SIZE-1:0]       wr_left;
  logic                      wr_load, wr_step, err_set, mem_we;
  logic [MEM_DEPTH_LOG-1:0]  mem_widx;

  rd_state_t                 rd_state, rd_state_nx;
  logic [CNT_W-1:0]          rd_cnt;
  logic [AVL_ADDR-1:0]       rd_addr;
  logic [AVL_SIZE-1:0]       rd_left;
  logic                      beat_go;
  logic [AVL_DATA_WIDTH-1:0] beat_word;

  assign stall_tick = (STALL_EVERY != 0) && (stall_cnt == ST_W'(STALL_EVERY - 1));
  assign avl_ready  = run && !rq_full && !stall_tick;
  assign wr_acc     = avl_write_req && avl_ready;
  assign rd_acc     = avl_read_req && avl_ready;

  // Free-running stall counter; run keeps avl_ready low while in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run       <= 1'b0;
      stall_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (STALL_EVERY > 1) stall_cnt <= stall_tick ? '0 : stall_cnt + 1'b1;
    end
  end

  avl_rq_fifo #(
    .WIDTH     (RQ_W),
    .DEPTH_LOG (RQ_DEPTH_LOG)
  ) u_rq_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rq_push),
    .push_data ({avl_addr, avl_size}),
    .pop       (rq_pop),
    .pop_data  (rq_head),
    .full      (rq_full),
    .empty     (rq_empty)
  );

  // Write FSM next state: accepts write beats and read commands, flags protocol errors.
  always_comb begin
    wr_state_nx = wr_state;
    mem_we      = 1'b0;
    mem_widx    = avl_addr[MEM_DEPTH_LOG-1:0];
    rq_push     = 1'b0;
    err_set     = 1'b0;
    wr_load     = 1'b0;
    wr_step     = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (wr_acc) begin
          // Simultaneous read is dropped in favour of the write.
          if (avl_read_req) err_set = 1'b1;
          if (avl_burstbegin) begin
            if (avl_size == '0) begin
              err_set = 1'b1;
            end else begin
              mem_we  = 1'b1;
              wr_load = 1'b1;
              if (avl_size > AVL_SIZE'(1)) wr_state_nx = WR_BURST;
            end
          end
        end else if (rd_acc) begin
          if (avl_size == '0) err_set = 1'b1;
          else                rq_push = 1'b1;
        end
      end
      WR_BURST: begin
        if (avl_read_req) err_set = 1'b1;
        if (wr_acc) begin
          mem_we   = 1'b1;
          mem_widx = wr_addr[MEM_DEPTH_LOG-1:0];
          wr_step  = 1'b1;
          if (wr_left == AVL_SIZE'(1)) wr_state_nx = WR_IDLE;
        end
      end
      default: wr_state_nx = WR_IDLE;
    endcase
  end

  // Write FSM state, burst address/count and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state <= WR_IDLE;
      wr_addr  <= '0;
      wr_left  <= '0;
      prot_err <= 1'b0;
    end else begin
      wr_state <= wr_state_nx;
      if (wr_load) begin
        wr_addr <= avl_addr + 1'b1;
        wr_left <= avl_size - 1'b1;
      end else if (wr_step) begin
        wr_addr <= wr_addr + 1'b1;
        wr_left <= wr_left - 1'b1;
      end
      if (err_set) prot_err <= 1'b1;
    end
  end

  // Byte-enabled memory write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < AVL_BE; b++)
        if (avl_be[b]) mem[mem_widx][b*8 +: 8] <= avl_wdata[b*8 +: 8];
    end
  end

  // Beat fetch with bypass so a write landing on this edge is seen by the beat.
  always_comb begin
    beat_word = mem[rd_addr[MEM_DEPTH_LOG-1:0]];
    if (mem_we && (mem_widx == rd_addr[MEM_DEPTH_LOG-1:0]))
      beat_word = be_merge(beat_word, avl_wdata, avl_be);
  end

  // Return FSM next state: the beat is registered on the edge that leaves the
  // final wait cycle, so the countdown ends at 1 rather than 0.
  always_comb begin
    rd_state_nx = rd_state;
    rq_pop      = 1'b0;
    beat_go     = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (!rq_empty) begin
          rq_pop      = 1'b1;
          rd_state_nx = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_cnt == CNT_W'(1)) begin
          beat_go     = 1'b1;
          rd_state_nx = RD_BEAT;
        end
      end
      RD_BEAT: begin
        if (rd_left != '0) begin
          beat_go = 1'b1;
        end else if (!rq_empty) begin
          rq_pop      = 1'b1;
          rd_state_nx = RD_WAIT;
        end else begin
          rd_state_nx = RD_IDLE;
        end
      end
      default: rd_state_nx = RD_IDLE;
    endcase
  end

  // Return FSM state, countdown, burst tracking and registered read outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state        <= RD_IDLE;
      rd_cnt          <= '0;
      rd_addr         <= '0;
      rd_left         <= '0;
      avl_rdata       <= '0;
      avl_rdata_valid <= 1'b0;
    end else begin
      rd_state <= rd_state_nx;
      if (rq_pop) begin
        rd_cnt  <= CNT_W'(RD_LATENCY - 1);
        rd_addr <= rq_head[RQ_W-1:AVL_SIZE];
        rd_left <= rq_head[AVL_SIZE-1:0];
      end else if (rd_state == RD_WAIT) begin
        rd_cnt <= rd_cnt - 1'b1;
      end
      if (beat_go) begin
        rd_addr   <= rd_addr + 1'b1;
        rd_left   <= rd_left - 1'b1;
        avl_rdata <= beat_word;
      end
      avl_rdata_valid <= beat_go;
    end
  end

endmodule

// File: tb/tb_avl_ddr_responder.sv
// Directed bench for avl_ddr_responder with a shadow memory and an expected-beat queue.
module tb_avl_ddr_responder;

  localparam int AW = 30, SW = 3, BW = 32, DW = 256, ML = 10;
  localparam int LAT = 8, RQL = 2, STALL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          avl_ready;
  logic [AW-1:0] avl_addr;
  logic [SW-1:0] avl_size;
  logic [DW-1:0] avl_wdata;
  logic [DW-1:0] avl_rdata;
  logic          avl_write_req;
  logic          avl_read_req;
  logic          avl_rdata_valid;
  logic [BW-1:0] avl_be;
  logic          avl_burstbegin;
  logic          prot_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] shadow [1 << ML];
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  avl_ddr_responder #(
    .AVL_ADDR(AW), .AVL_SIZE(SW), .AVL_BE(BW), .AVL_DATA_WIDTH(DW),
    .MEM_DEPTH_LOG(ML), .RD_LATENCY(LAT), .RQ_DEPTH_LOG(RQL), .STALL_EVERY(STALL)
  ) dut (
    .clk(clk), .reset(reset), .avl_ready(avl_ready), .avl_addr(avl_addr),
    .avl_size(avl_size), .avl_wdata(avl_wdata), .avl_rdata(avl_rdata),
    .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
    .avl_rdata_valid(avl_rdata_valid), .avl_be(avl_be),
    .avl_burstbegin(avl_burstbegin), .prot_err(prot_err)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every returned beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (reset === 1'b1 && avl_rdata_valid === 1'b1) begin
      chk("beat_expected", DW'(exp_q.size() != 0), DW'(1));
      if (exp_q.size() != 0) chk("rdata", avl_rdata, exp_q.pop_front());
    end
  end

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic idle_inputs();
    avl_write_req  = 1'b0;
    avl_read_req   = 1'b0;
    avl_burstbegin = 1'b0;
    avl_addr       = '0;
    avl_size       = '0;
    avl_wdata      = '0;
    avl_be         = '0;
  endtask

  task automatic shadow_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    for (int b = 0; b < BW; b++)
      if (be[b]) shadow[a[ML-1:0]][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // Called at a negedge with the request driven; returns at the negedge after acceptance.
  task automatic wait_accept(input string tag);
    int guard;
    guard = 0;
    while (avl_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_accept"}, DW'(avl_ready), DW'(1));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input int n, input logic [BW-1:0] be, input bit mid_read);
    logic [DW-1:0] d;
    logic [AW-1:0] ai;
    for (int i = 0; i < n; i++) begin
      if (i == 1 && mid_read) begin
        avl_write_req  = 1'b0;
        avl_burstbegin = 1'b1;
        avl_read_req   = 1'b1;
        @(negedge clk);
        avl_read_req   = 1'b0;
      end
      d = rand_word();
      ai = a + AW'(i);
      avl_write_req  = 1'b1;
      avl_burstbegin = (i == 0);
      avl_addr       = a;
      avl_size       = SW'(n);
      avl_wdata      = d;
      avl_be         = be;
      wait_accept("wr");
      shadow_wr(ai, d, be);
    end
    idle_inputs();
  endtask

  task automatic rd_cmd(input logic [AW-1:0] a, input int n);
    logic [AW-1:0] ai;
    avl_read_req   = 1'b1;
    avl_burstbegin = 1'b1;
    avl_addr       = a;
    avl_size       = SW'(n);
    wait_accept("rd");
    for (int i = 0; i < n; i++) begin
      ai = a + AW'(i);
      exp_q.push_back(shadow[ai[ML-1:0]]);
    end
    idle_inputs();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", DW'(exp_q.size()), DW'(0));
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("rst_ready", DW'(avl_ready), DW'(0));
    chk("rst_rdata", avl_rdata, DW'(0));
    chk("rst_valid", DW'(avl_rdata_valid), DW'(0));
    chk("rst_prot_err", DW'(prot_err), DW'(0));
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int n, lows, last_low, gap_bad;
    logic [DW-1:0] d;

    do_reset();

    // Single beat write/read with exact latency.
    wr_burst(30'h10, 1, '1, 1'b0);
    rd_cmd(30'h10, 1);
    n = 0;
    while (avl_rdata_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rd_latency", DW'(n), DW'(LAT));
    @(negedge clk);
    chk("valid_one_cycle", DW'(avl_rdata_valid), DW'(0));
    drain();

    // Burst across the top of memory wraps to index 0.
    wr_burst(30'h3FF, 4, '1, 1'b0);
    rd_cmd(30'h3FF, 4);
    drain();

    // Partial write over a known word.
    wr_burst(30'h20, 1, '1, 1'b0);
    wr_burst(30'h20, 1, 32'h0000000F, 1'b0);
    rd_cmd(30'h20, 1);
    drain();

    // Stall cadence with an idle read engine.
    lows = 0; last_low = -1; gap_bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (avl_ready !== 1'b1) begin
        if (last_low >= 0 && i - last_low != STALL) gap_bad++;
        last_low = i;
        lows++;
      end
      @(negedge clk);
    end
    chk("stall_lows", DW'(lows), DW'(4));
    chk("stall_gap", DW'(gap_bad), DW'(0));

    // Long continuous bursts through the stalls, read back intact.
    wr_burst(30'h100, 7, '1, 1'b0);
    wr_burst(30'h107, 7, '1, 1'b0);
    rd_cmd(30'h100, 7);
    rd_cmd(30'h107, 7);
    drain();

    // Fill the read-command FIFO: one popped, four queued, then ready stays low.
    for (int i = 0; i < 5; i++) rd_cmd(30'h100 + AW'(2 * i), 4);
    chk("full_ready0", DW'(avl_ready), DW'(0));
    @(negedge clk);
    chk("full_ready1", DW'(avl_ready), DW'(0));
    @(negedge clk);
    chk("full_ready2", DW'(avl_ready), DW'(0));
    rd_cmd(30'h108, 3);
    drain();
    chk("prot_clean", DW'(prot_err), DW'(0));

    // Read during a write burst: ignored, flagged, burst still completes.
    wr_burst(30'h200, 2, '1, 1'b1);
    chk("prot_mid_burst", DW'(prot_err), DW'(1));
    rd_cmd(30'h200, 2);
    drain();
    chk("prot_sticky", DW'(prot_err), DW'(1));

    // Zero-size read: dropped and flagged.
    do_reset();
    rd_cmd(30'h200, 0);
    repeat (16) @(negedge clk);
    chk("prot_size0", DW'(prot_err), DW'(1));
    chk("size0_no_beats", DW'(exp_q.size()), DW'(0));

    // Read and write together: write wins, read dropped.
    do_reset();
    d = rand_word();
    avl_write_req  = 1'b1;
    avl_read_req   = 1'b1;
    avl_burstbegin = 1'b1;
    avl_addr       = 30'h40;
    avl_size       = 3'd1;
    avl_wdata      = d;
    avl_be         = '1;
    wait_accept("rw");
    shadow_wr(30'h40, d, '1);
    idle_inputs();
    chk("prot_rw", DW'(prot_err), DW'(1));
    repeat (16) @(negedge clk);
    chk("rw_read_dropped", DW'(exp_q.size()), DW'(0));
    rd_cmd(30'h40, 1);
    drain();
    chk("prot_rw_sticky", DW'(prot_err), DW'(1));

    // Reset in the middle of a read burst drops the remaining beats.
    rd_cmd(30'h3FF, 4);
    n = 0;
    while (avl_rdata_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_valid_seen", DW'(avl_rdata_valid), DW'(1));
    #2;
    do_reset();
    repeat (20) @(negedge clk);
    chk("midrst_no_resume", DW'(avl_rdata_valid), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
